ram_param: RTL

Parametrised dual-port synchronous RAM for the Máquina Sencilla with I/O, successor to the fixed 128×16 single-port RAM. Port A serves the CPU datapath, and port B serves the I/O subsystem (DMA-style peripheral access). After every reset, a built-in clear engine sweeps the whole array to a programmable value before either port is served. Same-address write collisions are resolved deterministically and flagged.

---
 rtl/ram_param.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ram_param.sv
// Dual-port synchronous RAM with a post-reset clear sweep, port-A-wins write collisions and registered reads.
// Define RAM_PARIDAD_EN to store an even-parity bit per word and add the err_par_a/err_par_b outputs.
module ram_param #(
   parameter int                     ANCHO_DATOS = 16,
   parameter int                     ANCHO_DIR   = 7,
   parameter int                     PROF        = 128,
   parameter logic [ANCHO_DATOS-1:0] VALOR_INI   = '0,
   parameter int                     MODO_LECT   = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   le_a,
   input  logic [ANCHO_DIR-1:0]   dir_a,
   input  logic [ANCHO_DATOS-1:0] ent_a,
   output logic [ANCHO_DATOS-1:0] sal_a,
   input  logic                   le_b,
   input  logic [ANCHO_DIR-1:0]   dir_b,
   input  logic [ANCHO_DATOS-1:0] ent_b,
   output logic [ANCHO_DATOS-1:0] sal_b,
`ifdef RAM_PARIDAD_EN
   output logic                   err_par_a,
   output logic                   err_par_b,
`endif
   output logic                   ocupado,
   output logic                   colision
);

   localparam logic [0:0] BORRAR = 1'b0;
   localparam logic [0:0] NORMAL = 1'b1;

`ifdef RAM_PARIDAD_EN
   localparam int AP = ANCHO_DATOS + 1;
`else
   localparam int AP = ANCHO_DATOS;
`endif

   localparam logic [ANCHO_DIR:0]   LIM = (ANCHO_DIR+1)'(PROF);
   localparam logic [ANCHO_DIR-1:0] ULT = ANCHO_DIR'(PROF - 1);

   function automatic logic [AP-1:0] palabra(input logic [ANCHO_DATOS-1:0] d);
`ifdef RAM_PARIDAD_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   logic [AP-1:0]          mem_q [PROF];
   logic [0:0]             estado_q, estado_d;
   logic [ANCHO_DIR-1:0]   cnt_q, cnt_d;
   logic [ANCHO_DATOS-1:0] sal_a_q, sal_a_d, sal_b_q, sal_b_d;
   logic                   col_q, col_d;
   logic                   en_a, en_b, we_a, we_b, colis;
   logic [AP-1:0]          rd_a, rd_b;
`ifdef RAM_PARIDAD_EN
   logic                   epa_q, epa_d, epb_q, epb_d;
`endif

   // Out-of-range addresses are masked here so they never write, read or collide.
   assign en_a = ({1'b0, dir_a} < LIM);
   assign en_b = ({1'b0, dir_b} < LIM);
   assign rd_a = en_a ? mem_q[dir_a] : '0;
   assign rd_b = en_b ? mem_q[dir_b] : '0;

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      sal_a_d  = '0;
      sal_b_d  = '0;
      col_d    = 1'b0;
      we_a     = 1'b0;
      we_b     = 1'b0;
      colis    = 1'b0;
`ifdef RAM_PARIDAD_EN
      epa_d    = 1'b0;
      epb_d    = 1'b0;
`endif
      if (estado_q == BORRAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == ULT) begin
            estado_d = NORMAL;
            cnt_d    = '0;
         end
      end else begin
         we_a  = le_a & en_a;
         colis = we_a & le_b & en_b & (dir_a == dir_b);
         we_b  = le_b & en_b & ~colis;
         col_d = colis;
         // Cross-port reads always see pre-edge contents; only own-port write-first differs.
         if (en_a)
            sal_a_d = (le_a && MODO_LECT == 1) ? ent_a : rd_a[ANCHO_DATOS-1:0];
         if (en_b) begin
            if (le_b && MODO_LECT == 1)
               sal_b_d = colis ? ent_a : ent_b;
            else
               sal_b_d = rd_b[ANCHO_DATOS-1:0];
         end
`ifdef RAM_PARIDAD_EN
         epa_d = en_a & ~le_a & (^rd_a);
         epb_d = en_b & ~le_b & (^rd_b);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= BORRAR;
         cnt_q    <= '0;
         sal_a_q  <= '0;
         sal_b_q  <= '0;
         col_q    <= 1'b0;
`ifdef RAM_PARIDAD_EN
         epa_q    <= 1'b0;
         epb_q    <= 1'b0;
`endif
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         sal_a_q  <= sal_a_d;
         sal_b_q  <= sal_b_d;
         col_q    <= col_d;
`ifdef RAM_PARIDAD_EN
         epa_q    <= epa_d;
         epb_q    <= epb_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (estado_q == BORRAR) begin
            mem_q[cnt_q] <= palabra(VALOR_INI);
         end else begin
            if (we_a) mem_q[dir_a] <= palabra(ent_a);
            if (we_b) mem_q[dir_b] <= palabra(ent_b);
         end
      end
   end

   assign sal_a    = sal_a_q;
   assign sal_b    = sal_b_q;
   assign colision = col_q;
   assign ocupado  = (estado_q == BORRAR);
`ifdef RAM_PARIDAD_EN
   assign err_par_a = epa_q;
   assign err_par_b = epb_q;
`endif

endmodule
